// File: rtl/painterengine_gpu_dma_reader.sv
// painterengine_gpu_dma_reader
// AXI4 read master: fetches length[k] words from address[k] for the channel picked by
// the one-hot router, in INCR bursts that never cross a 1 KB boundary, and hands each
// word to consumer k through a one-word output register.
module painterengine_gpu_dma_reader #(
   parameter int PARAM_TIMEOUT = 256
) (
   input  logic         i_wire_clock,
   input  logic         i_wire_resetn,
   input  logic [3:0]   i_wire_router,
   output logic         o_wire_done,
   input  logic [127:0] i_wire_address,
   input  logic [127:0] i_wire_length,
   output logic [127:0] o_wire_data,
   output logic [3:0]   o_wire_data_valid,
   input  logic [3:0]   i_wire_data_next,
   output logic         o_wire_error,
   output logic [2:0]   o_wire_error_type,
   output logic         o_wire_M_AXI_ARID,
   output logic [31:0]  o_wire_M_AXI_ARADDR,
   output logic [7:0]   o_wire_M_AXI_ARLEN,
   output logic [2:0]   o_wire_M_AXI_ARSIZE,
   output logic [1:0]   o_wire_M_AXI_ARBURST,
   output logic         o_wire_M_AXI_ARLOCK,
   output logic [3:0]   o_wire_M_AXI_ARCACHE,
   output logic [2:0]   o_wire_M_AXI_ARPROT,
   output logic [3:0]   o_wire_M_AXI_ARQOS,
   output logic         o_wire_M_AXI_ARVALID,
   input  logic         i_wire_M_AXI_ARREADY,
   input  logic         i_wire_M_AXI_RID,
   input  logic [31:0]  i_wire_M_AXI_RDATA,
   input  logic [1:0]   i_wire_M_AXI_RRESP,
   input  logic         i_wire_M_AXI_RLAST,
   input  logic         i_wire_M_AXI_RVALID,
   output logic         o_wire_M_AXI_RREADY
);

   localparam int TW = $clog2(PARAM_TIMEOUT + 1);

   // Bit 4 flags an error, bits 2:0 are then the error type.
   typedef enum logic [4:0] {
      ST_ROUTING     = 5'h01,
      ST_PARAM_CHECK = 5'h02,
      ST_CALC        = 5'h03,
      ST_ADDR        = 5'h04,
      ST_DATA        = 5'h05,
      ST_DONE        = 5'h07,
      ST_ROUTING_ERR = 5'h10,
      ST_ALIGN_ERR   = 5'h11,
      ST_LENGTH_ERR  = 5'h12,
      ST_AR_TIMEOUT  = 5'h13,
      ST_R_TIMEOUT   = 5'h14,
      ST_RRESP_ERR   = 5'h15,
      ST_RLAST_ERR   = 5'h16
   } state_t;

   state_t          state_r, state_next_s;
   logic [1:0]      chan_r;
   logic [31:0]     addr_r, length_r, offset_r, araddr_r, data_r;
   logic [8:0]      beats_r, count_r;
   logic [TW-1:0]   timeout_r;
   logic            arvalid_r, full_r;

   logic            route_ok_s;
   logic [1:0]      route_ch_s;
   logic [3:0]      chan_onehot_s;
   logic            next_sel_s, rready_s, r_hs_s, r_stall_s, last_beat_s, beat_ok_s, timeout_hit_s;
   logic [7:0]      unalign_s;
   logic [8:0]      room_s, beats_calc_s, arlen_s;
   logic [31:0]     remain_s;
   logic [32:0]     offset_end_s;
   logic            unused_s;

   // Decode the one-hot router into a channel index; anything else is a routing error
   always_comb begin
      route_ok_s = 1'b1;
      route_ch_s = 2'd0;
      case (i_wire_router)
         4'b0001: route_ch_s = 2'd0;
         4'b0010: route_ch_s = 2'd1;
         4'b0100: route_ch_s = 2'd2;
         4'b1000: route_ch_s = 2'd3;
         default: route_ok_s = 1'b0;
      endcase
   end

   // Handshake qualifiers and the burst-size arithmetic used in CALC
   always_comb begin
      chan_onehot_s = 4'b0001 << chan_r;
      next_sel_s    = |(i_wire_data_next & chan_onehot_s);
      rready_s      = (state_r == ST_DATA) && (!full_r || next_sel_s);
      r_hs_s        = rready_s && i_wire_M_AXI_RVALID;
      r_stall_s     = rready_s && !i_wire_M_AXI_RVALID;
      last_beat_s   = (count_r == (beats_r - 9'd1));
      beat_ok_s     = r_hs_s && !i_wire_M_AXI_RRESP[1] && (i_wire_M_AXI_RLAST == last_beat_s);
      timeout_hit_s = (timeout_r == TW'(PARAM_TIMEOUT - 1));
      unalign_s     = addr_r[9:2] + offset_r[7:0];
      room_s        = 9'd256 - {1'b0, unalign_s};
      remain_s      = length_r - offset_r;
      if (remain_s < {23'd0, room_s}) begin
         beats_calc_s = remain_s[8:0];
      end else begin
         beats_calc_s = room_s;
      end
      offset_end_s  = {1'b0, offset_r} + {24'd0, beats_r};
      arlen_s       = beats_r - 9'd1;
   end

   // Next-state logic; DONE and every error state hold until reset
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_ROUTING: begin
            if (route_ok_s) state_next_s = ST_PARAM_CHECK;
            else            state_next_s = ST_ROUTING_ERR;
         end
         ST_PARAM_CHECK: begin
            if (addr_r[1:0] != 2'd0)      state_next_s = ST_ALIGN_ERR;
            else if (length_r == 32'd0)   state_next_s = ST_LENGTH_ERR;
            else                          state_next_s = ST_CALC;
         end
         ST_CALC: state_next_s = ST_ADDR;
         ST_ADDR: begin
            if (arvalid_r && i_wire_M_AXI_ARREADY) state_next_s = ST_DATA;
            else if (arvalid_r && timeout_hit_s)   state_next_s = ST_AR_TIMEOUT;
            else                                   state_next_s = ST_ADDR;
         end
         ST_DATA: begin
            if (r_hs_s) begin
               if (i_wire_M_AXI_RRESP[1])                  state_next_s = ST_RRESP_ERR;
               else if (i_wire_M_AXI_RLAST != last_beat_s) state_next_s = ST_RLAST_ERR;
               else if (!last_beat_s)                      state_next_s = ST_DATA;
               else if (offset_end_s >= {1'b0, length_r})  state_next_s = ST_DONE;
               else                                        state_next_s = ST_CALC;
            end else if (r_stall_s && timeout_hit_s) begin
               state_next_s = ST_R_TIMEOUT;
            end else begin
               state_next_s = ST_DATA;
            end
         end
         default: state_next_s = state_r;
      endcase
   end

   // State register
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) state_r <= ST_ROUTING;
      else                state_r <= state_next_s;
   end

   // Transfer bookkeeping: channel latch, burst setup, AR valid, beat and timeout counters
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         chan_r    <= 2'd0;
         addr_r    <= 32'd0;
         length_r  <= 32'd0;
         offset_r  <= 32'd0;
         araddr_r  <= 32'd0;
         beats_r   <= 9'd1;
         count_r   <= 9'd0;
         timeout_r <= {TW{1'b0}};
         arvalid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_ROUTING: begin
               if (route_ok_s) begin
                  chan_r   <= route_ch_s;
                  addr_r   <= i_wire_address[{route_ch_s, 5'd0} +: 32];
                  length_r <= i_wire_length[{route_ch_s, 5'd0} +: 32];
               end
            end
            ST_CALC: begin
               beats_r   <= beats_calc_s;
               araddr_r  <= addr_r + {offset_r[29:0], 2'b00};
               arvalid_r <= 1'b0;
               timeout_r <= {TW{1'b0}};
            end
            ST_ADDR: begin
               if (arvalid_r && i_wire_M_AXI_ARREADY) begin
                  arvalid_r <= 1'b0;
                  count_r   <= 9'd0;
                  timeout_r <= {TW{1'b0}};
               end else if (arvalid_r && timeout_hit_s) begin
                  arvalid_r <= 1'b0;
               end else if (arvalid_r) begin
                  timeout_r <= timeout_r + TW'(1);
               end else begin
                  arvalid_r <= 1'b1;
               end
            end
            ST_DATA: begin
               if (beat_ok_s) begin
                  count_r   <= count_r + 9'd1;
                  timeout_r <= {TW{1'b0}};
                  if (last_beat_s) offset_r <= offset_end_s[31:0];
               end else if (r_stall_s) begin
                  timeout_r <= timeout_r + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // One-word output register; a load in the same cycle as a drain keeps it full
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         full_r <= 1'b0;
         data_r <= 32'd0;
      end else if (beat_ok_s) begin
         full_r <= 1'b1;
         data_r <= i_wire_M_AXI_RDATA;
      end else if (full_r && next_sel_s) begin
         full_r <= 1'b0;
      end
   end

   // Place the held word on the selected channel's slice only
   always_comb begin
      o_wire_data       = 128'd0;
      o_wire_data_valid = 4'd0;
      if (full_r) begin
         o_wire_data[{chan_r, 5'd0} +: 32] = data_r;
         o_wire_data_valid                 = chan_onehot_s;
      end else begin
         o_wire_data_valid = 4'd0;
      end
   end

   assign o_wire_done          = (state_r == ST_DONE);
   assign o_wire_error         = state_r[4];
   assign o_wire_error_type    = state_r[4] ? state_r[2:0] : 3'd0;
   assign o_wire_M_AXI_ARID    = 1'b0;
   assign o_wire_M_AXI_ARADDR  = araddr_r;
   assign o_wire_M_AXI_ARLEN   = arlen_s[7:0];
   assign o_wire_M_AXI_ARSIZE  = 3'b010;
   assign o_wire_M_AXI_ARBURST = 2'b01;
   assign o_wire_M_AXI_ARLOCK  = 1'b0;
   assign o_wire_M_AXI_ARCACHE = 4'b0010;
   assign o_wire_M_AXI_ARPROT  = 3'b000;
   assign o_wire_M_AXI_ARQOS   = 4'b0000;
   assign o_wire_M_AXI_ARVALID = arvalid_r;
   assign o_wire_M_AXI_RREADY  = rready_s;

   // RID is ignored (single outstanding ID); RRESP[0] does not distinguish OKAY/EXOKAY from errors
   assign unused_s = &{1'b0, i_wire_M_AXI_RID, i_wire_M_AXI_RRESP[0], arlen_s[8]};

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for painterengine_gpu_dma_reader: a random-latency AXI slave, a queue-based
// reference model of bursts and words, and a monitor that pops and compares.
module tb_painterengine_gpu_dma_reader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]   router = 4'd0;
   logic         done;
   logic [127:0] address = 128'd0, length = 128'd0, data;
   logic [3:0]   data_valid, data_next = 4'd0;
   logic         error;
   logic [2:0]   error_type;
   logic         arid, arlock, arvalid, arready = 1'b0;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize, arprot;
   logic [1:0]   arburst;
   logic [3:0]   arcache, arqos;
   logic         rid = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready;
   logic [31:0]  rdata = 32'd0;
   logic [1:0]   rresp = 2'd0;

   painterengine_gpu_dma_reader dut (
      .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_router(router), .o_wire_done(done),
      .i_wire_address(address), .i_wire_length(length), .o_wire_data(data),
      .o_wire_data_valid(data_valid), .i_wire_data_next(data_next),
      .o_wire_error(error), .o_wire_error_type(error_type),
      .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
      .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst), .o_wire_M_AXI_ARLOCK(arlock),
      .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
      .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
      .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
      .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } ar_t;

   ar_t         exp_ar[$];
   logic [31:0] exp_word[$];
   ar_t         slave_q[$];

   int   compared = 0;
   int   mismatched = 0;
   int   cur_ch = 0;
   int   cur_ekind = 0;
   logic mon_en = 1'b0;

   // Memory contents seen by the slave: a bijective scramble of the byte address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: split [addr, addr+4*len) into bursts ending at 1 KB boundaries
   task automatic build_model(input logic [31:0] addr, input logic [31:0] len,
                              input int ar_keep, input int word_keep);
      longint off, room, b, wi;
      int n_ar, n_w;
      off = 0; n_ar = 0; n_w = 0;
      while (off < longint'(len)) begin
         wi   = longint'(addr) / 4 + off;
         room = 256 - (wi % 256);
         b    = (longint'(len) - off < room) ? longint'(len) - off : room;
         if (ar_keep < 0 || n_ar < ar_keep) begin
            exp_ar.push_back(ar_t'{32'(longint'(addr) + off * 4), 8'(b - 1)});
            n_ar++;
         end
         off += b;
      end
      for (longint i = 0; i < longint'(len); i++) begin
         if (word_keep < 0 || n_w < word_keep) begin
            exp_word.push_back(mem(32'(longint'(addr) + i * 4)));
            n_w++;
         end
      end
   endtask

   // Monitor: pops the scoreboard on every AR handshake and every consumer accept
   initial begin
      ar_t         e;
      logic [31:0] w, prev_rdata;
      logic [127:0] others;
      logic        prev_hs;
      prev_hs = 1'b0;
      prev_rdata = 32'd0;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && rst_n) begin
            if (prev_hs) begin
               check("latency_valid", 64'(data_valid[cur_ch]), 64'd1);
               check("latency_data", 64'(data[cur_ch*32 +: 32]), 64'(prev_rdata));
            end
            prev_hs    = rvalid && rready && (cur_ekind == 0);
            prev_rdata = rdata;
            if (arvalid && arready) begin
               if (exp_ar.size() == 0) begin
                  check("ar_extra", 64'd1, 64'd0);
               end else begin
                  e = exp_ar.pop_front();
                  check("araddr", 64'(araddr), 64'(e.addr));
                  check("arlen", 64'(arlen), 64'(e.len));
               end
               check("ar_const", 64'({arid, arsize, arburst, arlock, arcache, arprot, arqos}),
                     64'({1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000}));
            end
            if (data_valid != 4'd0) begin
               check("valid_onehot", 64'(data_valid), 64'(4'b0001 << cur_ch));
               others = data;
               others[cur_ch*32 +: 32] = 32'd0;
               check("other_slices_zero", 64'(others == 128'd0), 64'd1);
            end
            if (data_valid[cur_ch] && data_next[cur_ch]) begin
               if (exp_word.size() == 0) begin
                  check("word_extra", 64'd1, 64'd0);
               end else begin
                  w = exp_word.pop_front();
                  check("word", 64'(data[cur_ch*32 +: 32]), 64'(w));
               end
            end
         end else begin
            prev_hs = 1'b0;
         end
      end
   end

   // Stimulus: consumer next pattern plus a random-latency AXI read slave
   task automatic drive(input int nmode, input int ar_never, input int r_never, input int ekind,
                        input int ebeat, input int max_cyc, output int cyc_end);
      int beat, gbeat;
      logic pend;
      beat = 0; gbeat = 0; pend = 1'b0; cyc_end = -1;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         @(negedge clk);
         case (nmode)
            0:       data_next = 4'hF;
            1:       data_next = 4'($urandom_range(0, 15));
            default: data_next = (cyc >= 40 && cyc < 90) ? 4'h0 : 4'hF;
         endcase
         arready = (ar_never != 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (!pend) begin
            if (r_never == 0 && slave_q.size() > 0 && $urandom_range(0, 3) != 0) begin
               rvalid = 1'b1;
               rdata  = mem(slave_q[0].addr + 32'(beat * 4));
               rlast  = (beat == int'(slave_q[0].len));
               rresp  = 2'b00;
               if (ekind == 1 && gbeat == ebeat) rresp = 2'b10;
               if (ekind == 2 && gbeat == ebeat) rlast = 1'b1;
            end else begin
               rvalid = 1'b0;
               rlast  = 1'b0;
            end
         end
         #1;
         if (arvalid && arready) slave_q.push_back(ar_t'{araddr, arlen});
         pend = rvalid && !rready;
         if (rvalid && rready) begin
            gbeat++;
            beat++;
            if (beat > int'(slave_q[0].len)) begin
               void'(slave_q.pop_front());
               beat = 0;
            end
         end
         if ((done || error) && data_valid == 4'd0) begin
            cyc_end = cyc;
            break;
         end
      end
   endtask

   task automatic run_test(input logic [3:0] rtr, input int ch, input logic [31:0] addr,
                           input logic [31:0] len, input int nmode, input int ar_never,
                           input int r_never, input int ekind, input int ebeat,
                           input int exp_err, input int exp_type, input int ar_keep,
                           input int word_keep, input int reset_at);
      int cyc_end;
      @(negedge clk);
      #3;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0; arready = 1'b0; data_next = 4'd0;
      exp_ar.delete(); exp_word.delete(); slave_q.delete();
      address = {$urandom, $urandom, $urandom, $urandom};
      length  = {$urandom, $urandom, $urandom, $urandom};
      address[ch*32 +: 32] = addr;
      length[ch*32 +: 32]  = len;
      router    = rtr;
      cur_ch    = ch;
      cur_ekind = ekind;
      build_model(addr, len, ar_keep, word_keep);
      #1;
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'({error, error_type}), 64'd0);
      check("rst_valid", 64'(data_valid), 64'd0);
      check("rst_data", 64'(data != 128'd0), 64'd0);
      check("rst_ar", 64'({arvalid, araddr, arlen}), 64'd0);
      check("rst_rready", 64'(rready), 64'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      drive(nmode, ar_never, r_never, ekind, ebeat, (reset_at > 0) ? reset_at : 8000, cyc_end);
      @(negedge clk);
      #3;
      if (reset_at > 0) begin
         mon_en = 1'b0;
         rst_n  = 1'b0;
         #1;
         check("mid_rst_status", 64'({done, error, error_type}), 64'd0);
         check("mid_rst_stream", 64'({data != 128'd0, data_valid}), 64'd0);
         check("mid_rst_axi", 64'({arvalid, rready, araddr, arlen}), 64'd0);
      end else begin
         if (cyc_end < 0) check("end_budget", 64'd0, 64'd1);
         check("done", 64'(done), 64'(exp_err == 0));
         check("error", 64'(error), 64'(exp_err != 0));
         check("error_type", 64'(error_type), 64'(exp_type));
         check("ar_left", 64'(exp_ar.size()), 64'd0);
         check("words_left", 64'(exp_word.size()), 64'd0);
         if (ar_never != 0) check("ar_timeout_window", 64'(cyc_end >= 250 && cyc_end <= 275), 64'd1);
      end
   endtask

   initial begin
      int ch;
      logic [31:0] a, l;
      // Basic, boundary-split, multi-burst and stalled-consumer transfers
      run_test(4'b0010, 1, 32'h0000_1000, 32'd4,   0, 0, 0, 0, 0, 0, 0, -1, -1, 0);
      run_test(4'b0001, 0, 32'h0000_03F8, 32'd10,  0, 0, 0, 0, 0, 0, 0, -1, -1, 0);
      run_test(4'b1000, 3, 32'h0000_0000, 32'd600, 0, 0, 0, 0, 0, 0, 0, -1, -1, 0);
      run_test(4'b0100, 2, 32'h0000_0200, 32'd100, 2, 0, 0, 0, 0, 0, 0, -1, -1, 0);
      // Error paths
      run_test(4'b0011, 0, 32'h0000_1000, 32'd4,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      run_test(4'b0000, 0, 32'h0000_1000, 32'd4,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      run_test(4'b0010, 1, 32'h0000_1002, 32'd4,   0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      run_test(4'b0100, 2, 32'h0000_1000, 32'd0,   0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      run_test(4'b0001, 0, 32'h0000_1000, 32'd4,   0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
      run_test(4'b0001, 0, 32'h0000_1000, 32'd4,   0, 0, 1, 0, 0, 1, 4, 1, 0, 0);
      run_test(4'b1000, 3, 32'h0000_0040, 32'd8,   0, 0, 0, 1, 2, 1, 5, 1, 2, 0);
      run_test(4'b0010, 1, 32'h0000_0040, 32'd8,   0, 0, 0, 2, 2, 1, 6, 1, 2, 0);
      // Reset in the middle of a burst
      run_test(4'b0100, 2, 32'h0000_0100, 32'd300, 1, 0, 0, 0, 0, 0, 0, -1, -1, 40);
      // Randomized transfers with random consumer back-pressure and slave latency
      for (int t = 0; t < 8; t++) begin
         ch = $urandom_range(0, 3);
         a  = 32'($urandom_range(0, 16383)) << 2;
         l  = 32'($urandom_range(1, 600));
         run_test(4'b0001 << ch, ch, a, l, 1, 0, 0, 0, 0, 0, 0, -1, -1, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
